led_seq_ctrl: RTL and testbench

Button-driven mode controller for the LED shifter. Debounces four raw push-buttons, runs a small state machine and drives the shifter's 4-bit switch word (enable, speed select, colour select) in place of the physical switches. An optional demo mode steps through all speed/colour combinations automatically. Sits between the board buttons and the shifter's switch input, on the same clock.

---
 rtl/led_ctrl_pkg.sv | 23 ++
 rtl/led_seq_ctrl_btn_debounce.sv | 47 ++++
 rtl/led_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_led_seq_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED shifter mode controller: FSM states,
// switch-word bit positions and button bit positions.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEMO = 2'd2
  } state_t;

  // Switch word driven to the shifter: {color, sel[1:0], enable}
  localparam int SW_EN      = 0;
  localparam int SW_SEL_LSB = 1;
  localparam int SW_SEL_MSB = 2;
  localparam int SW_COLOR   = 3;

  // Push-button bit positions on i_btn
  localparam int BTN_RUN  = 0;
  localparam int BTN_SPD  = 1;
  localparam int BTN_COL  = 2;
  localparam int BTN_DEMO = 3;

endpackage

// File: rtl/led_seq_ctrl_btn_debounce.sv
// Single push-button debouncer: two-flop synchroniser, stability counter
// and a one-cycle registered press pulse on a stable 0->1 transition.
module btn_debounce #(
  parameter int NB_DEB = 10
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  logic              sync1_q;
  logic              sync2_q;
  logic              stable_q;
  logic              press_q;
  logic [NB_DEB-1:0] cnt_q;

  // Synchronise the raw level, then accept it only after it has differed
  // from the stable level for 2^NB_DEB consecutive cycles.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (&cnt_q) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
        press_q  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + NB_DEB'(1);
      end
    end
  end

  assign o_level = stable_q;
  assign o_press = press_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Button-driven mode controller for the LED shifter. Debounces four buttons,
// runs the IDLE/RUN(/DEMO) state machine and drives the registered switch
// word {color, sel, enable}. Manual override passes i_sw_man straight through.
// Optional feature: define LED_SEQ_DEMO_EN to build the DEMO state, its dwell
// counter and the demo button; otherwise button 3 is ignored.
module led_seq_ctrl #(
  parameter int N_BTN   = 4,
  parameter int NB_SEL  = 2,
  parameter int NB_SW   = 4,
  parameter int NB_DEB  = 10,
  parameter int NB_DEMO = 24
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn,
  input  logic             i_ovr,
  input  logic [NB_SW-1:0] i_sw_man,
  output logic [NB_SW-1:0] o_sw,
  output logic [1:0]       o_state
);

  import led_ctrl_pkg::*;

  logic [N_BTN-1:0]  btn_level;
  logic [N_BTN-1:0]  btn_press;

  state_t            state_q, state_d;
  logic [NB_SEL-1:0] sel_q, sel_d;
  logic              color_q, color_d;
  logic [NB_SW-1:0]  sw_q, sw_d;
`ifdef LED_SEQ_DEMO_EN
  logic [NB_DEMO-1:0] dwell_q, dwell_d;
`endif

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(.NB_DEB(NB_DEB)) u_deb (
      .clock   (clock),
      .i_reset (i_reset),
      .i_btn   (i_btn[g]),
      .o_level (btn_level[g]),
      .o_press (btn_press[g])
    );
  end

  // Stable levels are not needed here; the demo press is unused without demo.
  logic unused_btn;
`ifdef LED_SEQ_DEMO_EN
  assign unused_btn = ^btn_level;
`else
  assign unused_btn = ^{btn_level, btn_press[BTN_DEMO]};
`endif

  // Next-state and next-output logic; override freezes state and config.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    color_d = color_q;
`ifdef LED_SEQ_DEMO_EN
    dwell_d = dwell_q;
`endif
    if (!i_ovr) begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (btn_press[BTN_RUN]) begin
            // Run/stop wins over any other press in the same cycle.
            if (state_q == ST_IDLE) state_d = ST_RUN;
            else                    state_d = ST_IDLE;
          end else begin
            if (btn_press[BTN_SPD]) sel_d = sel_q + NB_SEL'(1);
            if (btn_press[BTN_COL]) color_d = ~color_q;
`ifdef LED_SEQ_DEMO_EN
            if ((state_q == ST_IDLE) && btn_press[BTN_DEMO]) begin
              state_d = ST_DEMO;
              dwell_d = '0;
            end
`endif
          end
        end
`ifdef LED_SEQ_DEMO_EN
        ST_DEMO: begin
          if (btn_press[BTN_RUN]) begin
            state_d = ST_IDLE;
          end else begin
            dwell_d = dwell_q + NB_DEMO'(1);
            if (&dwell_q) begin
              sel_d = sel_q + NB_SEL'(1);
              if (&sel_q) color_d = ~color_q;
            end
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    sw_d = '0;
    if (i_ovr) begin
      sw_d = i_sw_man;
    end else begin
      sw_d[SW_EN]                  = (state_d != ST_IDLE);
      sw_d[SW_SEL_MSB:SW_SEL_LSB]  = sel_d;
      sw_d[SW_COLOR]               = color_d;
    end
  end

  // State, configuration and registered switch word.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      color_q <= 1'b0;
      sw_q    <= '0;
`ifdef LED_SEQ_DEMO_EN
      dwell_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      color_q <= color_d;
      sw_q    <= sw_d;
`ifdef LED_SEQ_DEMO_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  assign o_sw    = sw_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl with NB_DEB=4, NB_DEMO=6.
// Stimulus pushes cycle-tagged expected {o_sw, o_state}; the monitor pops
// and compares on the falling edge of the tagged cycle.
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic       ovr;
  logic [3:0] sw_man;
  logic [3:0] sw;
  logic [1:0] st;

  typedef struct {
    int         cyc;
    logic [3:0] sw;
    logic [1:0] st;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_test = 0;
  int   n_fail = 0;
  bit   flush  = 1'b0;

  led_seq_ctrl #(
    .N_BTN   (4),
    .NB_SEL  (2),
    .NB_SW   (4),
    .NB_DEB  (4),
    .NB_DEMO (6)
  ) dut (
    .clock    (clk),
    .i_reset  (rst_n),
    .i_btn    (btn),
    .i_ovr    (ovr),
    .i_sw_man (sw_man),
    .o_sw     (sw),
    .o_state  (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged with the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && (q[0].cyc <= cyc || flush)) begin
      e = q.pop_front();
      n_test++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: not checked at cycle %0d (now %0d), o_sw=%h o_state=%0d", e.nm, e.cyc, cyc, sw, st);
      end else if (sw !== e.sw || st !== e.st) begin
        n_fail++;
        $display("FAIL %s: o_sw=%h o_state=%0d, required o_sw=%h o_state=%0d", e.nm, sw, st, e.sw, e.st);
      end
    end
  end

  task automatic expect_at(input int dly, input logic [3:0] esw, input logic [1:0] est, input string nm);
    exp_t e;
    e.cyc = cyc + dly;
    e.sw  = esw;
    e.st  = est;
    e.nm  = nm;
    q.push_back(e);
  endtask

  // Drive a button mask for 30 cycles. The response is due 19 cycles after
  // the drive point: 2 sync + 16 debounce edges give the pulse, +1 to register.
  task automatic press(input logic [3:0] mask, input logic [3:0] pre_sw, input logic [1:0] pre_st,
                       input logic [3:0] post_sw, input logic [1:0] post_st, input string nm);
    @(negedge clk);
    btn = mask;
    expect_at(18, pre_sw, pre_st, {nm, "_pre"});
    expect_at(19, post_sw, post_st, {nm, "_post"});
    repeat (30) @(negedge clk);
    btn = 4'h0;
    repeat (22) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    btn    = 4'h0;
    ovr    = 1'b0;
    sw_man = 4'h0;

    // Reset held, then released
    @(negedge clk);
    expect_at(1, 4'h0, 2'd0, "rst_held");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_at(1, 4'h0, 2'd0, "rst_released");
    repeat (2) @(negedge clk);

    // Run/stop toggling with exact press latency
    press(4'b0001, 4'h0, 2'd0, 4'h1, 2'd1, "run_on");
    press(4'b0001, 4'h1, 2'd1, 4'h0, 2'd0, "run_off");

    // 10-cycle glitch on speed button: no change
    @(negedge clk);
    btn = 4'b0010;
    repeat (10) @(negedge clk);
    btn = 4'h0;
    repeat (25) @(negedge clk);
    expect_at(1, 4'h0, 2'd0, "glitch");
    repeat (2) @(negedge clk);

    // Speed stepping with wrap, then colour toggle, in RUN
    press(4'b0001, 4'h0, 2'd0, 4'h1, 2'd1, "run_on2");
    press(4'b0010, 4'h1, 2'd1, 4'h3, 2'd1, "spd1");
    press(4'b0010, 4'h3, 2'd1, 4'h5, 2'd1, "spd2");
    press(4'b0010, 4'h5, 2'd1, 4'h7, 2'd1, "spd3");
    press(4'b0010, 4'h7, 2'd1, 4'h1, 2'd1, "spd_wrap");
    press(4'b0100, 4'h1, 2'd1, 4'h9, 2'd1, "color");

    // Simultaneous run/stop and speed: stop wins, sel unchanged
    press(4'b0010, 4'h9, 2'd1, 4'hB, 2'd1, "spd_b");
    press(4'b0011, 4'hB, 2'd1, 4'hA, 2'd0, "stop_prio");

    // Override in RUN
    press(4'b0001, 4'hA, 2'd0, 4'hB, 2'd1, "run_on3");
    @(negedge clk);
    ovr    = 1'b1;
    sw_man = 4'hA;
    expect_at(1, 4'hA, 2'd1, "ovr_on");
    press(4'b0001, 4'hA, 2'd1, 4'hA, 2'd1, "ovr_ignore");
    @(negedge clk);
    sw_man = 4'h5;
    expect_at(1, 4'h5, 2'd1, "ovr_follow");
    repeat (2) @(negedge clk);
    ovr = 1'b0;
    expect_at(1, 4'hB, 2'd1, "ovr_off");
    repeat (3) @(negedge clk);

    // Asynchronous reset in RUN, checked before any further rising edge
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expect_at(0, 4'h0, 2'd0, "async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_at(1, 4'h0, 2'd0, "post_rst");
    repeat (3) @(negedge clk);

    // Demo button from IDLE after reset (sel=0, color=0)
    @(negedge clk);
    btn = 4'b1000;
`ifdef LED_SEQ_DEMO_EN
    expect_at(18,  4'h0, 2'd0, "demo_pre");
    expect_at(19,  4'h1, 2'd2, "demo_enter");
    expect_at(82,  4'h1, 2'd2, "demo_dwell");
    expect_at(83,  4'h3, 2'd2, "demo_step1");
    expect_at(147, 4'h5, 2'd2, "demo_step2");
    expect_at(211, 4'h7, 2'd2, "demo_step3");
    expect_at(274, 4'h7, 2'd2, "demo_pre_wrap");
    expect_at(275, 4'h9, 2'd2, "demo_wrap");
`else
    expect_at(19, 4'h0, 2'd0, "demo_off");
    expect_at(60, 4'h0, 2'd0, "demo_off_late");
`endif
    repeat (30) @(negedge clk);
    btn = 4'h0;
    repeat (245) @(negedge clk);
`ifdef LED_SEQ_DEMO_EN
    press(4'b0001, 4'h9, 2'd2, 4'h8, 2'd0, "demo_exit");
`else
    press(4'b0001, 4'h0, 2'd0, 4'h1, 2'd1, "run_after_demo");
`endif

    repeat (3) @(negedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
